// File: rtl/control_pid.sv
// ============================================================================
//  Module      : control_pid
//  Description : Incremental (velocity-form) I-PD servo controller. Integral
//                action on the error, P and D action on the measured output.
//                One shared 12x14 multiplier is time-multiplexed over three
//                multiply states. An optional output clamp is selected by
//                defining CONTROL_PID_SAT_EN; otherwise the result wraps.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_pid (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        dataf_i,
    input  logic [11:0] y_k_i,
    input  logic [11:0] ref_i,
    input  logic [11:0] coeff_1,
    input  logic [11:0] coeff_2,
    input  logic [11:0] coeff_3,
    output logic [11:0] servo_o,
    output logic        dataf_oo
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIFF   = 3'd1,
        MUL_I  = 3'd2,
        MUL_P  = 3'd3,
        MUL_D  = 3'd4,
        UPDATE = 3'd5
    } state_t;

    state_t state, state_next;

    logic               dataf_prev;
    logic               start;
    logic               latch_en;

    // Latched operands for the update in flight
    logic signed [11:0] y_lat, r_lat, ki_lat, kp_lat, kd_lat;
    // History
    logic signed [11:0] y1, y2, u1;
    // Differences and products
    logic signed [12:0] e, d1;
    logic signed [13:0] d2;
    logic signed [25:0] p_i, p_p, p_d;

    logic signed [11:0] mul_a;
    logic signed [13:0] mul_b;
    logic signed [25:0] product;
    logic signed [27:0] sum;
    logic signed [11:0] u_next;

    // Rising-edge detect; a high level through reset must not start an update
    assign start = dataf_i & ~dataf_prev;

    // State register and start-edge history
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            state      <= IDLE;
            dataf_prev <= 1'b1;
        end else begin
            state      <= state_next;
            dataf_prev <= dataf_i;
        end
    end

    // Next-state logic; start edges outside IDLE are simply dropped
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch_en   = 1'b1;
                    state_next = DIFF;
                end
            end
            DIFF:    state_next = MUL_I;
            MUL_I:   state_next = MUL_P;
            MUL_P:   state_next = MUL_D;
            MUL_D:   state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared multiplier operand select
    always_comb begin
        mul_a = ki_lat;
        mul_b = {e[12], e};
        case (state)
            MUL_P: begin
                mul_a = kp_lat;
                mul_b = {d1[12], d1};
            end
            MUL_D: begin
                mul_a = kd_lat;
                mul_b = d2;
            end
            default: ;
        endcase
    end

    assign product = mul_a * mul_b;

    // Exact 28-bit accumulation; cannot overflow for any 12-bit operands
    assign sum = 28'(u1) + 28'(p_i) - 28'(p_p) - 28'(p_d);

    // Reduce to the 12-bit actuator word
    always_comb begin
`ifdef CONTROL_PID_SAT_EN
        if (sum > 28'sd2047)
            u_next = 12'sh7FF;
        else if (sum < -28'sd2048)
            u_next = 12'sh800;
        else
            u_next = 12'(sum);
`else
        u_next = 12'(sum);
`endif
    end

    // Datapath: operand latch, differences, products, output and history
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            y_lat    <= '0;
            r_lat    <= '0;
            ki_lat   <= '0;
            kp_lat   <= '0;
            kd_lat   <= '0;
            y1       <= '0;
            y2       <= '0;
            u1       <= '0;
            e        <= '0;
            d1       <= '0;
            d2       <= '0;
            p_i      <= '0;
            p_p      <= '0;
            p_d      <= '0;
            servo_o  <= '0;
            dataf_oo <= 1'b0;
        end else begin
            dataf_oo <= 1'b0;
            if (latch_en) begin
                y_lat  <= y_k_i;
                r_lat  <= ref_i;
                ki_lat <= coeff_1;
                kp_lat <= coeff_2;
                kd_lat <= coeff_3;
            end
            case (state)
                DIFF: begin
                    e  <= 13'(r_lat) - 13'(y_lat);
                    d1 <= 13'(y_lat) - 13'(y1);
                    d2 <= 14'(y_lat) - {y1[11], y1, 1'b0} + 14'(y2);
                end
                MUL_I: p_i <= product;
                MUL_P: p_p <= product;
                MUL_D: p_d <= product;
                UPDATE: begin
                    servo_o  <= u_next;
                    dataf_oo <= 1'b1;
                    u1       <= u_next;
                    y2       <= y1;
                    y1       <= y_lat;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_pid.sv
// ============================================================================
//  Module      : tb_control_pid
//  Description : Self-checking bench for control_pid: fixed vector table,
//                hand-written corner sequences, and randomized samples checked
//                against an integer model of the control law.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_pid;

    logic        clk_i = 1'b0;
    logic        reset = 1'b0;
    logic        dataf_i = 1'b0;
    logic [11:0] y_k_i = '0;
    logic [11:0] ref_i = '0;
    logic [11:0] coeff_1 = '0;
    logic [11:0] coeff_2 = '0;
    logic [11:0] coeff_3 = '0;
    logic [11:0] servo_o;
    logic        dataf_oo;

    int checks = 0;
    int errors = 0;

    control_pid dut (
        .clk_i   (clk_i),
        .reset   (reset),
        .dataf_i (dataf_i),
        .y_k_i   (y_k_i),
        .ref_i   (ref_i),
        .coeff_1 (coeff_1),
        .coeff_2 (coeff_2),
        .coeff_3 (coeff_3),
        .servo_o (servo_o),
        .dataf_oo(dataf_oo)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int y;
        int r;
        int ki;
        int kp;
        int kd;
        int exp_u;
    } vec_t;

    vec_t vecs[4];

    // Reference model state: previous outputs and previous command
    int m_y1 = 0, m_y2 = 0, m_u1 = 0;

    function automatic int reduce12(input int v);
`ifdef CONTROL_PID_SAT_EN
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
`else
        int m;
        m = v & 32'hFFF;
        return (m >= 2048) ? m - 4096 : m;
`endif
    endfunction

    task automatic model_step(input int y, input int r, input int ki,
                              input int kp, input int kd, output int u);
        int raw;
        raw = m_u1 + ki * (r - y) - kp * (y - m_y1) - kd * (y - 2 * m_y1 + m_y2);
        u = reduce12(raw);
        m_u1 = u;
        m_y2 = m_y1;
        m_y1 = y;
    endtask

    function automatic int rnd12();
        logic [11:0] v;
        v = 12'($urandom);
        return int'($signed(v));
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset = 1'b0;
        repeat (2) @(negedge clk_i);
        reset = 1'b1;
        m_y1 = 0;
        m_y2 = 0;
        m_u1 = 0;
    endtask

    // One full update: rise, scramble inputs after the start edge, check timing and value
    task automatic run_sample(input string name, input int y, input int r, input int ki,
                              input int kp, input int kd, input int exp_u);
        int early;
        early = 0;
        @(negedge clk_i);
        dataf_i = 1'b0;
        @(negedge clk_i);
        y_k_i   = 12'(y);
        ref_i   = 12'(r);
        coeff_1 = 12'(ki);
        coeff_2 = 12'(kp);
        coeff_3 = 12'(kd);
        dataf_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (dataf_oo) early++;
            if (k == 0) begin
                dataf_i = 1'b0;
                y_k_i   = ~y_k_i;
                ref_i   = ~ref_i;
                coeff_1 = ~coeff_1;
                coeff_2 = ~coeff_2;
                coeff_3 = ~coeff_3;
            end
        end
        check({name, " early_pulse"}, early, 0);
        @(negedge clk_i);
        check({name, " done"}, int'(dataf_oo), 1);
        check({name, " servo"}, int'($signed(servo_o)), exp_u);
        @(negedge clk_i);
        check({name, " done_end"}, int'(dataf_oo), 0);
    endtask

    initial begin : main
        int u;
        int pulses;
        int y, r, ki, kp, kd;

        vecs[0] = '{y: 0, r: 10, ki: 2, kp: 4, kd: 6, exp_u: 20};
        vecs[1] = '{y: 5, r: 10, ki: 2, kp: 4, kd: 6, exp_u: -20};
        vecs[2] = '{y: 5, r: 10, ki: 2, kp: 4, kd: 6, exp_u: 20};
        vecs[3] = '{y: 0, r: 0,  ki: 1, kp: 1, kd: 1, exp_u: 30};

        do_reset();
        @(negedge clk_i);
        check("reset servo", int'($signed(servo_o)), 0);
        check("reset done", int'(dataf_oo), 0);

        // Fixed vectors
        for (int i = 0; i < 4; i++) begin
            model_step(vecs[i].y, vecs[i].r, vecs[i].ki, vecs[i].kp, vecs[i].kd, u);
            run_sample($sformatf("vec%0d", i), vecs[i].y, vecs[i].r, vecs[i].ki,
                       vecs[i].kp, vecs[i].kd, vecs[i].exp_u);
        end

        // Large integral term: saturate or wrap
        do_reset();
`ifdef CONTROL_PID_SAT_EN
        run_sample("sat", 0, 2047, 2047, 0, 0, 2047);
`else
        run_sample("wrap", 0, 2047, 2047, 0, 0, 1);
`endif

        // Level held, then a rise while busy: exactly one update
        do_reset();
        model_step(0, 10, 2, 4, 6, u);
        @(negedge clk_i);
        y_k_i = 12'd0; ref_i = 12'd10; coeff_1 = 12'd2; coeff_2 = 12'd4; coeff_3 = 12'd6;
        dataf_i = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (dataf_oo) pulses++;
            if (k == 2) dataf_i = 1'b0;
            if (k == 3) dataf_i = 1'b1;
        end
        dataf_i = 1'b0;
        check("busy_rise pulses", pulses, 1);
        check("busy_rise servo", int'($signed(servo_o)), u);

        // Reset asserted while in MUL_P aborts the update
        @(negedge clk_i);
        y_k_i = 12'd7; ref_i = 12'd100; coeff_1 = 12'd3;
        dataf_i = 1'b1;
        @(negedge clk_i);
        dataf_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset = 1'b0;
        @(negedge clk_i);
        reset = 1'b1;
        m_y1 = 0; m_y2 = 0; m_u1 = 0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (dataf_oo) pulses++;
        end
        check("abort pulses", pulses, 0);
        check("abort servo", int'($signed(servo_o)), 0);
        model_step(0, 10, 2, 4, 6, u);
        run_sample("after_abort", 0, 10, 2, 4, 6, 20);

        // Strobe high across reset release must not start an update
        @(negedge clk_i);
        reset = 1'b0;
        dataf_i = 1'b1;
        y_k_i = 12'd0; ref_i = 12'd50; coeff_1 = 12'd1; coeff_2 = 12'd0; coeff_3 = 12'd0;
        repeat (2) @(negedge clk_i);
        reset = 1'b1;
        m_y1 = 0; m_y2 = 0; m_u1 = 0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (dataf_oo) pulses++;
        end
        check("held_reset pulses", pulses, 0);
        check("held_reset servo", int'($signed(servo_o)), 0);
        model_step(0, 50, 1, 0, 0, u);
        run_sample("held_reset_next", 0, 50, 1, 0, 0, u);

        // Randomized samples against the model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            y  = rnd12();
            r  = rnd12();
            if (i < 20) begin
                ki = int'($urandom_range(0, 15)) - 8;
                kp = int'($urandom_range(0, 15)) - 8;
                kd = int'($urandom_range(0, 15)) - 8;
            end else begin
                ki = rnd12();
                kp = rnd12();
                kd = rnd12();
            end
            model_step(y, r, ki, kp, kd, u);
            run_sample($sformatf("rand%0d", i), y, r, ki, kp, kd, u);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
